vga_plot_arbiter: RTL and testbench

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

---
 rtl/vga_plot_arbiter.sv | 176 +++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Two-requester pixel plot arbiter with a full-screen clear sweep feeding one VGA pixel port.
// Define VGA_PLOT_CLIP_EN to acknowledge off-screen requests without plotting them.
module vga_plot_arbiter #(
  parameter int unsigned XRES = 160,
  parameter int unsigned YRES = 120
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       req0,
  input  logic       req1,
  input  logic [9:0] x0,
  input  logic [9:0] x1,
  input  logic [8:0] y0,
  input  logic [8:0] y1,
  input  logic [2:0] c0,
  input  logic [2:0] c1,
  output logic       ack0,
  output logic       ack1,
  input  logic       clear,
  input  logic [2:0] clear_color,
  output logic       busy,
  output logic       done,
  output logic [9:0] VGA_X,
  output logic [8:0] VGA_Y,
  output logic [2:0] VGA_COLOR,
  output logic       plot
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned CW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          plot_q, plot_d;
  logic [XW-1:0] vga_x_q, vga_x_d;
  logic [YW-1:0] vga_y_q, vga_y_d;
  logic [CW-1:0] vga_color_q, vga_color_d;
  logic [XW-1:0] cnt_x_q, cnt_x_d;
  logic [YW-1:0] cnt_y_q, cnt_y_d;
  logic [CW-1:0] clr_color_q, clr_color_d;

  logic          elig0, elig1, sel0, sel1;
  logic [XW-1:0] gnt_x;
  logic [YW-1:0] gnt_y;
  logic [CW-1:0] gnt_c;
  logic          gnt_on_screen;

  // A request already being acknowledged this cycle is still held; skip it to avoid a double grant.
  assign elig0 = req0 & ~ack0_q;
  assign elig1 = req1 & ~ack1_q;
  assign sel1  = elig1 & (~elig0 | ptr_q);
  assign sel0  = elig0 & ~sel1;

  assign gnt_x = sel1 ? x1 : x0;
  assign gnt_y = sel1 ? y1 : y0;
  assign gnt_c = sel1 ? c1 : c0;

`ifdef VGA_PLOT_CLIP_EN
  assign gnt_on_screen = (32'(gnt_x) < XRES) && (32'(gnt_y) < YRES);
`else
  assign gnt_on_screen = 1'b1;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    plot_d      = 1'b0;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    cnt_x_d     = cnt_x_q;
    cnt_y_d     = cnt_y_q;
    clr_color_d = clr_color_q;

    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d     = CLEAR;
          busy_d      = 1'b1;
          clr_color_d = clear_color;
          cnt_x_d     = '0;
          cnt_y_d     = '0;
        end else if (sel0 || sel1) begin
          ack0_d = sel0;
          ack1_d = sel1;
          ptr_d  = sel0;
          if (gnt_on_screen) begin
            plot_d      = 1'b1;
            vga_x_d     = gnt_x;
            vga_y_d     = gnt_y;
            vga_color_d = gnt_c;
          end
        end
      end

      CLEAR: begin
        plot_d      = 1'b1;
        busy_d      = 1'b1;
        vga_x_d     = cnt_x_q;
        vga_y_d     = cnt_y_q;
        vga_color_d = clr_color_q;
        if (cnt_x_q == XW'(XRES - 1)) begin
          cnt_x_d = '0;
          if (cnt_y_q == YW'(YRES - 1)) begin
            cnt_y_d = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_y_d = cnt_y_q + YW'(1);
          end
        end else begin
          cnt_x_d = cnt_x_q + XW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      plot_q      <= 1'b0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      cnt_x_q     <= '0;
      cnt_y_q     <= '0;
      clr_color_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      plot_q      <= plot_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      cnt_x_q     <= cnt_x_d;
      cnt_y_q     <= cnt_y_d;
      clr_color_q <= clr_color_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign plot      = plot_q;
  assign VGA_X     = vga_x_q;
  assign VGA_Y     = vga_y_q;
  assign VGA_COLOR = vga_color_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed self-checking bench for vga_plot_arbiter on a 4x3 screen.
module tb_vga_plot_arbiter;

  logic       clk;
  logic       resetn;
  logic       req0, req1;
  logic [9:0] x0, x1;
  logic [8:0] y0, y1;
  logic [2:0] c0, c1;
  logic       ack0, ack1;
  logic       clear;
  logic [2:0] clear_color;
  logic       busy, done;
  logic [9:0] vga_x;
  logic [8:0] vga_y;
  logic [2:0] vga_color;
  logic       plot;

  int n_chk  = 0;
  int n_pass = 0;

  vga_plot_arbiter #(.XRES(4), .YRES(3)) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .req0       (req0),
    .req1       (req1),
    .x0         (x0),
    .x1         (x1),
    .y0         (y0),
    .y1         (y1),
    .c0         (c0),
    .c1         (c1),
    .ack0       (ack0),
    .ack1       (ack1),
    .clear      (clear),
    .clear_color(clear_color),
    .busy       (busy),
    .done       (done),
    .VGA_X      (vga_x),
    .VGA_Y      (vga_y),
    .VGA_COLOR  (vga_color),
    .plot       (plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dones;
    resetn = 1'b0; req0 = 1'b0; req1 = 1'b0; clear = 1'b0; clear_color = 3'd0;
    x0 = '0; y0 = '0; c0 = '0; x1 = '0; y1 = '0; c1 = '0;
    tick(); tick();
    chk("rst_plot", plot, 0);   chk("rst_ack0", ack0, 0);  chk("rst_ack1", ack1, 0);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);  chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);     chk("rst_c", vga_color, 0);
    resetn = 1'b1;

    // Single request from requester 0.
    req0 = 1'b1; x0 = 10'd5; y0 = 9'd7; c0 = 3'd3;
    tick();
    chk("r0_plot", plot, 1); chk("r0_x", vga_x, 5); chk("r0_y", vga_y, 7);
    chk("r0_c", vga_color, 3); chk("r0_ack0", ack0, 1); chk("r0_ack1", ack1, 0);
    tick();
    chk("r0_noregrant_plot", plot, 0); chk("r0_noregrant_ack", ack0, 0); chk("r0_hold_x", vga_x, 5);
    req0 = 1'b0;

    // Single request from requester 1 (returns pointer to requester 0).
    req1 = 1'b1; x1 = 10'd9; y1 = 9'd2; c1 = 3'd5;
    tick();
    chk("r1_ack1", ack1, 1); chk("r1_ack0", ack0, 0); chk("r1_x", vga_x, 9); chk("r1_c", vga_color, 5);
    req1 = 1'b0;
    tick();
    chk("r1_idle_plot", plot, 0); chk("r1_idle_ack1", ack1, 0);

    // Both held: strict alternation starting with requester 0.
    req0 = 1'b1; x0 = 10'd10; y0 = 9'd11; c0 = 3'd1;
    req1 = 1'b1; x1 = 10'd20; y1 = 9'd21; c1 = 3'd2;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_ack0", ack0, (k % 2 == 0) ? 1 : 0);
      chk("rr_ack1", ack1, (k % 2 == 1) ? 1 : 0);
      chk("rr_plot", plot, 1);
      chk("rr_x", vga_x, (k % 2 == 0) ? 10 : 20);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("rr_stop_plot", plot, 0);

    // Clear sweep with a request pending on requester 1.
    clear = 1'b1; clear_color = 3'd6;
    tick();
    chk("clr_busy", busy, 1); chk("clr_entry_plot", plot, 0); chk("clr_entry_ack0", ack0, 0);
    clear = 1'b0; clear_color = 3'd1;
    req1 = 1'b1; x1 = 10'd33; y1 = 9'd44; c1 = 3'd7;
    for (int i = 0; i < 12; i++) begin
      clear = (i == 3 || i == 4);
      tick();
      chk("clr_plot", plot, 1);
      chk("clr_x", vga_x, i % 4);
      chk("clr_y", vga_y, i / 4);
      chk("clr_c", vga_color, 6);
      chk("clr_busy", busy, 1);
      chk("clr_ack1", ack1, 0);
      chk("clr_done", done, (i == 11) ? 1 : 0);
    end
    clear = 1'b0;
    tick();
    chk("post_busy", busy, 0); chk("post_done", done, 0); chk("post_ack1", ack1, 1);
    chk("post_plot", plot, 1); chk("post_x", vga_x, 33); chk("post_y", vga_y, 44); chk("post_c", vga_color, 7);
    req1 = 1'b0;
    tick();
    chk("post_idle_ack1", ack1, 0); chk("post_idle_plot", plot, 0);

    // Reset at the 5th clear pixel aborts the sweep.
    clear = 1'b1; clear_color = 3'd5;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ab_plot", plot, 1);
    end
    resetn = 1'b0;
    tick();
    chk("ab_plot_rst", plot, 0); chk("ab_busy", busy, 0); chk("ab_done", done, 0);
    chk("ab_x", vga_x, 0); chk("ab_y", vga_y, 0); chk("ab_c", vga_color, 0);
    resetn = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dones++;
    end
    chk("ab_no_done", dones, 0); chk("ab_idle_busy", busy, 0); chk("ab_idle_plot", plot, 0);

    // Off-screen coordinate.
    req0 = 1'b1; x0 = 10'd200; y0 = 9'd2; c0 = 3'd2;
    tick();
    chk("off_ack0", ack0, 1);
`ifdef VGA_PLOT_CLIP_EN
    chk("off_plot", plot, 0); chk("off_x", vga_x, 0);
`else
    chk("off_plot", plot, 1); chk("off_x", vga_x, 200);
`endif
    req0 = 1'b0;
    tick();
    chk("off_idle_plot", plot, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
